regfile_mp_sb: RTL and testbench

- Parametrised successor to the pipeline register file: DEPTH = 2^ADDR_W registers of DATA_W bits, NUM_RD combinational read ports, one write port.
- Adds an optional write-to-read bypass, a per-register pending scoreboard for decode-stage hazard detection, and a sequential flush/clear engine.
- Adds an indexed debug read port.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

---
 rtl/regfile_mp_sb_if.sv | 31 +++
 rtl/regfile_mp_sb.sv | 96 +++++++++
 tb/tb_regfile_mp_sb.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus of the multi-port register file: read ports, write port,
// scoreboard set, clear handshake and debug read.
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req, dbg_addr,
        input  rd_data, rd_pend, clr_busy, clr_done, dbg_data
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, clr_req, dbg_addr,
        output rd_data, rd_pend, clr_busy, clr_done, dbg_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with optional write bypass, pending scoreboard
// and a sequential clear engine that zeroes x1..x(DEPTH-1) one entry per cycle.
module regfile_mp_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    regfile_mp_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr_ok, sb_ok, byp_ok;

    // Address 0 is hard-wired: neither writes nor scoreboard sets ever reach it.
    assign wr_ok  = (state_q == StIdle) && bus.wr_en && (bus.wr_addr != '0);
    assign sb_ok  = (state_q == StIdle) && bus.sb_set && (bus.sb_addr != '0);
    assign byp_ok = (BYPASS != 0) && wr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        case (state_q)
            StIdle: begin
                if (wr_ok) begin
                    regs_d[bus.wr_addr] = bus.wr_data;
                    pend_d[bus.wr_addr] = 1'b0;
                end
                // A set issued alongside a write belongs to a newer producer.
                if (sb_ok) begin
                    pend_d[bus.sb_addr] = 1'b1;
                end
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = ADDR_W'(1);
                end
            end
            StClear: begin
                regs_d[cnt_q] = '0;
                pend_d[cnt_q] = 1'b0;
                cnt_d         = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign hit  = byp_ok && (bus.wr_addr == addr);

        assign bus.rd_data[k*DATA_W +: DATA_W] = hit ? bus.wr_data : regs_q[addr];
        assign bus.rd_pend[k] = hit ? 1'b0 : pend_q[addr];
    end

    assign bus.dbg_data = regs_q[bus.dbg_addr];
    assign bus.clr_busy = (state_q == StClear);
    assign bus.clr_done = (state_q == StDone);
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a 4-port bypassing instance plus a 2-port non-bypassing one,
// with expected values queued from a shadow model and compared as outputs are sampled.
module tb_regfile_mp_sb;
    logic clk;
    logic rst_n;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] obs_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl_reg [32];
    logic        mdl_pend [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void expect_val(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        sb_q.push_back(x);
    endfunction

    function automatic logic [31:0] rd(input int k);
        return bus.rd_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] pd(input int k);
        return {31'b0, bus.rd_pend[k]};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0;  bus.wr_addr = '0; bus.wr_data = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0; bus.clr_req = 1'b0;
        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus0.sb_set = 1'b0; bus0.sb_addr = '0; bus0.clr_req = 1'b0;
        bus0.rd_addr = '0; bus0.dbg_addr = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        bus.rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mdl_reg[i]  = '0;
            mdl_pend[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        set_rd(5'd5, 5'd7, 5'd0, 5'd31);
        bus.dbg_addr = 5'd5;
        model_clear();
        rst_n = 1'b0;
        expect_val("reset_busy", 32'd0);
        expect_val("reset_done", 32'd0);
        expect_val("reset_dbg5", 32'd0);
        expect_val("reset_rd0", 32'd0);
        expect_val("reset_pend3", 32'd0);
        #3;
        obs_q.push_back({31'b0, bus.clr_busy});
        obs_q.push_back({31'b0, bus.clr_done});
        obs_q.push_back(bus.dbg_data);
        obs_q.push_back(rd(0));
        obs_q.push_back(pd(3));
        #9;
        rst_n = 1'b1;
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_bypass();
        next();
        bus.wr_en = 1'b1;  bus.wr_addr = 5'd5;  bus.wr_data = 32'hDEADBEEF;
        bus0.wr_en = 1'b1; bus0.wr_addr = 5'd5; bus0.wr_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd0, 5'd0, 5'd0);
        bus0.rd_addr = {5'd0, 5'd5};
        expect_val("byp1_same_cycle", 32'hDEADBEEF);
        expect_val("byp0_same_cycle", mdl_reg[5]);
        #3;
        obs_q.push_back(rd(0));
        obs_q.push_back(bus0.rd_data[31:0]);
        next();
        mdl_reg[5] = 32'hDEADBEEF;
        bus.wr_en = 1'b0;
        bus0.wr_en = 1'b0;
        expect_val("byp1_next_cycle", mdl_reg[5]);
        expect_val("byp0_next_cycle", mdl_reg[5]);
        #3;
        obs_q.push_back(rd(0));
        obs_q.push_back(bus0.rd_data[31:0]);
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
        idle_inputs();
    endtask

    task automatic test_reg_zero();
        next();
        bus.wr_en = 1'b1;  bus.wr_addr = 5'd0; bus.wr_data = 32'h12345678;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        bus.dbg_addr = 5'd0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                expect_val($sformatf("zero_rd%0d_p%0d", k, pass), 32'd0);
                expect_val($sformatf("zero_pend%0d_p%0d", k, pass), 32'd0);
            end
            expect_val($sformatf("zero_dbg_p%0d", pass), 32'd0);
            #3;
            for (int k = 0; k < 4; k++) begin
                obs_q.push_back(rd(k));
                obs_q.push_back(pd(k));
            end
            obs_q.push_back(bus.dbg_data);
            next();
            idle_inputs();
        end
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_scoreboard();
        next();
        set_rd(5'd7, 5'd7, 5'd0, 5'd0);
        bus.dbg_addr = 5'd7;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
        expect_val("sb_set_cycle_pend", {31'b0, mdl_pend[7]});
        #3;
        obs_q.push_back(pd(0));
        next();
        mdl_pend[7] = 1'b1;
        bus.sb_set = 1'b0;
        expect_val("sb_after_set_pend0", {31'b0, mdl_pend[7]});
        expect_val("sb_after_set_pend1", {31'b0, mdl_pend[7]});
        #3;
        obs_q.push_back(pd(0));
        obs_q.push_back(pd(1));
        next();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5;
        expect_val("sb_write_cycle_pend", 32'd0);
        expect_val("sb_write_cycle_data", 32'hA5);
        #3;
        obs_q.push_back(pd(0));
        obs_q.push_back(rd(0));
        next();
        mdl_reg[7] = 32'hA5; mdl_pend[7] = 1'b0;
        bus.wr_en = 1'b0;
        expect_val("sb_after_write_pend", {31'b0, mdl_pend[7]});
        expect_val("sb_after_write_dbg", mdl_reg[7]);
        #3;
        obs_q.push_back(pd(0));
        obs_q.push_back(bus.dbg_data);
        next();
        bus.wr_en = 1'b1;  bus.wr_addr = 5'd7; bus.wr_data = 32'h5A;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
        expect_val("sb_both_cycle_pend", 32'd0);
        #3;
        obs_q.push_back(pd(0));
        next();
        mdl_reg[7] = 32'h5A; mdl_pend[7] = 1'b1;
        idle_inputs();
        expect_val("sb_both_after_pend", {31'b0, mdl_pend[7]});
        expect_val("sb_both_after_data", mdl_reg[7]);
        #3;
        obs_q.push_back(pd(0));
        obs_q.push_back(rd(0));
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_clear();
        int  busy_cnt;
        bit  done_seen;
        for (int i = 1; i < 32; i++) begin
            next();
            bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = 32'(i);
            if (i > 1) mdl_reg[i-1] = 32'(i-1);
        end
        next();
        mdl_reg[31] = 32'd31;
        bus.wr_en = 1'b0;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
        bus.dbg_addr = 5'd17;
        expect_val("clr_fill_dbg17", mdl_reg[17]);
        #3;
        obs_q.push_back(bus.dbg_data);
        next();
        mdl_pend[9] = 1'b1;
        bus.sb_set = 1'b0;
        bus.clr_req = 1'b1;
        set_rd(5'd3, 5'd9, 5'd31, 5'd4);
        expect_val("clr_req_cycle_busy", 32'd0);
        expect_val("clr_fill_pend9", {31'b0, mdl_pend[9]});
        expect_val("clr_fill_rd31", mdl_reg[31]);
        #3;
        obs_q.push_back({31'b0, bus.clr_busy});
        obs_q.push_back(pd(1));
        obs_q.push_back(rd(2));
        next();
        bus.clr_req = 1'b0;
        busy_cnt  = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy_cnt == 2) begin
                bus.wr_en = 1'b1;  bus.wr_addr = 5'd3; bus.wr_data = 32'hFFFFFFFF;
                bus.sb_set = 1'b1; bus.sb_addr = 5'd4; bus.clr_req = 1'b1;
                // Entries x1, x2 are already cleared; x3 still holds its fill value.
                expect_val("clr_busy_no_bypass_x3", 32'd3);
            end
            #3;
            if (!bus.clr_busy) begin
                done_seen = bus.clr_done;
                break;
            end
            if (busy_cnt == 2) obs_q.push_back(rd(0));
            busy_cnt++;
            next();
            idle_inputs();
        end
        model_clear();
        expect_val("clr_busy_cycles", 32'd31);
        expect_val("clr_done_pulse", 32'd1);
        obs_q.push_back(32'(busy_cnt));
        obs_q.push_back({31'b0, done_seen});
        next();
        expect_val("clr_after_done", 32'd0);
        expect_val("clr_after_busy", 32'd0);
        #3;
        obs_q.push_back({31'b0, bus.clr_done});
        obs_q.push_back({31'b0, bus.clr_busy});
        for (int i = 1; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            expect_val($sformatf("clr_dbg_x%0d", i), mdl_reg[i]);
            #1;
            obs_q.push_back(bus.dbg_data);
        end
        for (int k = 0; k < 4; k++) begin
            expect_val($sformatf("clr_pend_port%0d", k), 32'd0);
            obs_q.push_back(pd(k));
        end
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_clear();
        next();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h10;
        next();
        bus.wr_addr = 5'd20; bus.wr_data = 32'h20;
        next();
        bus.wr_en = 1'b0;
        bus.clr_req = 1'b1;
        bus.dbg_addr = 5'd20;
        next();
        bus.clr_req = 1'b0;
        for (int c = 1; c < 10; c++) next();
        expect_val("rmid_busy_before", 32'd1);
        expect_val("rmid_dbg20_before", 32'h20);
        obs_q.push_back({31'b0, bus.clr_busy});
        obs_q.push_back(bus.dbg_data);
        #1;
        rst_n = 1'b0;
        model_clear();
        expect_val("rmid_busy_in_reset", 32'd0);
        expect_val("rmid_done_in_reset", 32'd0);
        expect_val("rmid_dbg20_in_reset", mdl_reg[20]);
        #1;
        obs_q.push_back({31'b0, bus.clr_busy});
        obs_q.push_back({31'b0, bus.clr_done});
        obs_q.push_back(bus.dbg_data);
        @(negedge clk);
        rst_n = 1'b1;
        next();
        bus.dbg_addr = 5'd10;
        expect_val("rmid_busy_after", 32'd0);
        expect_val("rmid_dbg10_after", mdl_reg[10]);
        #3;
        obs_q.push_back({31'b0, bus.clr_busy});
        obs_q.push_back(bus.dbg_data);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 32'hCAFE;
        next();
        mdl_reg[20] = 32'hCAFE;
        bus.wr_en = 1'b0;
        bus.dbg_addr = 5'd20;
        expect_val("rmid_new_write", mdl_reg[20]);
        #3;
        obs_q.push_back(bus.dbg_data);
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_multiport();
        logic [4:0]  wa [4];
        logic [31:0] wd [4];
        logic [4:0]  ra [4];
        wa = '{5'd3, 5'd9, 5'd17, 5'd31};
        wd = '{32'h33, 32'h99, 32'h1717, 32'h3131};
        for (int i = 0; i < 4; i++) begin
            next();
            bus.wr_en = 1'b1; bus.wr_addr = wa[i]; bus.wr_data = wd[i];
            bus.sb_set = (i == 2 || i == 3); bus.sb_addr = (i == 2) ? 5'd9 : 5'd31;
            if (i > 0) mdl_reg[wa[i-1]] = wd[i-1];
        end
        next();
        mdl_reg[31] = wd[3];
        mdl_pend[9] = 1'b1;
        mdl_pend[31] = 1'b1;
        idle_inputs();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) ra = '{5'd3, 5'd9, 5'd17, 5'd31};
            else           ra = '{5'd17, 5'd17, 5'd9, 5'd9};
            set_rd(ra[0], ra[1], ra[2], ra[3]);
            for (int k = 0; k < 4; k++) begin
                expect_val($sformatf("mp_p%0d_rd%0d_x%0d", pass, k, ra[k]), mdl_reg[ra[k]]);
                expect_val($sformatf("mp_p%0d_pend%0d_x%0d", pass, k, ra[k]),
                           {31'b0, mdl_pend[ra[k]]});
            end
            #2;
            for (int k = 0; k < 4; k++) begin
                obs_q.push_back(rd(k));
                obs_q.push_back(pd(k));
            end
        end
        foreach (obs_q[i]) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_q[i] !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.val);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rd_addr = '0;
        bus.dbg_addr = '0;
        test_reset();
        test_bypass();
        test_reg_zero();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        test_multiport();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
